// File: rtl/calc_exec_seq.sv
// Execute sequencer for the shared 16-bit add/sub/mul datapath (start/busy/done handshake).
// Optional CALC_OVF_EN adds a signed overflow flag and widens the multiply accumulator.
module calc_exec_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             start,
    input  logic [2:0]       operator_input,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
`ifdef CALC_OVF_EN
    ,
    output logic             overflow
`endif
);

`ifdef CALC_OVF_EN
    localparam int unsigned ACC_W = 2 * WIDTH;
`else
    localparam int unsigned ACC_W = WIDTH;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL,
        SIGN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q;
    logic             sign_q;
    logic [ACC_W-1:0] acc, mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] counter;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] addsub_res;
    logic [WIDTH-1:0] mul_res;
    logic             op_add, op_sub, op_mul;

    assign op_add = (operator_input == 3'b001);
    assign op_sub = (operator_input == 3'b010);
    assign op_mul = (operator_input == 3'b100);

    // Two's-complement magnitude; the most negative value maps to 0x8000 unsigned.
    assign mag_a = operand_a[WIDTH-1] ? (~operand_a) + WIDTH'(1) : operand_a;
    assign mag_b = operand_b[WIDTH-1] ? (~operand_b) + WIDTH'(1) : operand_b;

    assign addsub_res = sub_q ? (a_q - b_q) : (a_q + b_q);
    assign mul_res    = sign_q ? (~acc[WIDTH-1:0]) + WIDTH'(1) : acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_add || op_sub) begin
                        next_state = ADDSUB;
                    end else if (op_mul) begin
                        next_state = MUL;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            ADDSUB:  next_state = DONE;
            MUL:     next_state = (counter == CNT_W'(WIDTH - 1)) ? SIGN : MUL;
            SIGN:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sign_q  <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            counter <= '0;
            error   <= 1'b0;
            result  <= '0;
`ifdef CALC_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= operand_a;
                        b_q    <= operand_b;
                        sub_q  <= op_sub;
                        sign_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        error  <= 1'b0;
                        if (op_mul) begin
                            acc     <= '0;
                            mcand   <= ACC_W'(mag_a);
                            mplier  <= mag_b;
                            counter <= '0;
                        end else if (!(op_add || op_sub)) begin
                            error  <= 1'b1;
                            result <= '0;
`ifdef CALC_OVF_EN
                            overflow <= 1'b0;
`endif
                        end
                    end
                end
                ADDSUB: begin
                    result <= addsub_res;
`ifdef CALC_OVF_EN
                    overflow <= ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) == sub_q) &&
                                (addsub_res[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + CNT_W'(1);
                end
                SIGN: begin
                    result <= mul_res;
`ifdef CALC_OVF_EN
                    // A negative product may reach one past the positive limit.
                    overflow <= sign_q ? (acc > ACC_W'(2 ** (WIDTH - 1)))
                                       : (acc > ACC_W'(2 ** (WIDTH - 1) - 1));
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_exec_seq.sv
// Directed self-checking bench for calc_exec_seq: handshake timing, arithmetic wrap,
// illegal operators, start while busy and mid-operation reset (overflow under CALC_OVF_EN).
module tb_calc_exec_seq;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  operator_input = 3'b000;
    logic [15:0] operand_a = '0;
    logic [15:0] operand_b = '0;
    logic        busy, done, error;
    logic [15:0] result;
`ifdef CALC_OVF_EN
    logic        overflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    calc_exec_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk            (clk),
        .nRST           (nRST),
        .start          (start),
        .operator_input (operator_input),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .result         (result)
`ifdef CALC_OVF_EN
        ,
        .overflow       (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for done, check latency/result/flags, then IDLE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_lat, input logic exp_ovf);
        int  lat;
        bit  seen;
        bit  busy_bad;
        lat = 0;
        seen = 0;
        busy_bad = 0;
        @(negedge clk);
        start = 1'b1;
        operator_input = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = 16'h5A5A;
        operand_b = 16'hA5A5;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (!busy) busy_bad = 1;
            if (done) begin
                seen = 1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy_hold"}, 32'(busy_bad), 32'd0);
        check_eq({tag, "_result"}, 32'(result), 32'(exp_res));
        check_eq({tag, "_error"}, 32'(error), 32'(exp_err));
`ifdef CALC_OVF_EN
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        @(posedge clk);
        #1;
        check_eq({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        check_eq({tag, "_result_held"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int n_done;
        logic [15:0] first_res;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_error", 32'(error), 32'd0);
        check_eq("reset_result", 32'(result), 32'd0);
        @(negedge clk);
        nRST = 1'b1;

        run_op("add", 3'b001, 16'd1000, 16'd2345, 16'd3345, 1'b0, 1, 1'b0);
        run_op("sub", 3'b010, 16'd3, 16'd5, 16'hFFFE, 1'b0, 1, 1'b0);
        run_op("mul_nn", 3'b100, 16'hFFFD, 16'hFFFA, 16'd18, 1'b0, 17, 1'b0);
        run_op("mul_wrap", 3'b100, 16'hFFF4, 16'd3000, 16'h7360, 1'b0, 17, 1'b1);
        run_op("mul_128", 3'b100, 16'd128, 16'd256, 16'h8000, 1'b0, 17, 1'b1);
        run_op("mul_min", 3'b100, 16'h8000, 16'd1, 16'h8000, 1'b0, 17, 1'b0);
        run_op("mul_neg", 3'b100, 16'd7, 16'hFFFB, 16'hFFDD, 1'b0, 17, 1'b0);
        run_op("add_edge", 3'b001, 16'h8000, 16'h7FFF, 16'hFFFF, 1'b0, 1, 1'b0);
        run_op("add_ovf", 3'b001, 16'h7FFF, 16'd1, 16'h8000, 1'b0, 1, 1'b1);
        run_op("op011", 3'b011, 16'd9, 16'd9, 16'd0, 1'b1, 0, 1'b0);
        run_op("add_pre", 3'b001, 16'd4, 16'd6, 16'd10, 1'b0, 1, 1'b0);
        run_op("op000", 3'b000, 16'd9, 16'd9, 16'd0, 1'b1, 0, 1'b0);
        run_op("add_clr", 3'b001, 16'd2, 16'd2, 16'd4, 1'b0, 1, 1'b0);

        // Keep start asserted for the whole multiply; only the first request may run.
        @(negedge clk);
        start = 1'b1;
        operator_input = 3'b100;
        operand_a = 16'hFFF4;
        operand_b = 16'd3000;
        @(posedge clk);
        #1;
        operator_input = 3'b001;
        operand_a = 16'd1;
        operand_b = 16'd1;
        n_done = 0;
        first_res = '0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                n_done++;
                first_res = result;
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check_eq("spam_done_count", 32'(n_done), 32'd1);
        check_eq("spam_result", 32'(first_res), 32'h7360);
        check_eq("spam_idle", 32'(busy), 32'd0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1;
        operator_input = 3'b100;
        operand_a = 16'd100;
        operand_b = 16'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        nRST = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_result", 32'(result), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        run_op("add_after_rst", 3'b001, 16'd7, 16'd8, 16'd15, 1'b0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
